// File: rtl/aux_responder.sv
// aux_responder: CPU aux-bus target serving four scratch registers, a free-running
// timer with compare, a sticky match status/interrupt, and a tagged fixed-latency read return.
module aux_responder #(
   parameter logic [31:0] BASE_ADDR    = 32'hE000_0000,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_aux_request,
   input  logic [31:0] cpu_aux_addr,
   input  logic        cpu_aux_write,
   input  logic [3:0]  cpu_aux_wstrb,
   input  logic [31:0] cpu_aux_wdata,
   input  logic        cpu_aux_abort,
   output logic        cpu_aux_rvalid,
   output logic [31:0] cpu_aux_rdata,
   output logic [8:0]  cpu_aux_rtag,
   output logic        irq
);

   localparam logic [5:0] IDX_TIMER  = 6'd4;
   localparam logic [5:0] IDX_CMP    = 6'd5;
   localparam logic [5:0] IDX_STATUS = 6'd6;
   localparam logic [5:0] IDX_CTRL   = 6'd7;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // Request capture (cycle T)
   logic        hit;
   logic        pend_valid;
   logic        pend_write;
   logic [5:0]  pend_idx;
   logic [3:0]  pend_wstrb;
   logic [31:0] pend_wdata;
   logic        unused_addr_lsbs;

   assign hit              = cpu_aux_request && (cpu_aux_addr[31:8] == BASE_ADDR[31:8]);
   assign unused_addr_lsbs = ^cpu_aux_addr[1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_write <= 1'b0;
         pend_idx   <= '0;
         pend_wstrb <= '0;
         pend_wdata <= '0;
      end else begin
         pend_valid <= hit;
         if (hit) begin
            pend_write <= cpu_aux_write;
            pend_idx   <= cpu_aux_addr[7:2];
            pend_wstrb <= cpu_aux_wstrb;
            pend_wdata <= cpu_aux_wdata;
         end
      end
   end

   // Commit (cycle T+1): abort only cancels the slot captured last cycle
   logic wr_commit;
   logic rd_commit;

   assign wr_commit = pend_valid && !cpu_aux_abort && pend_write;
   assign rd_commit = pend_valid && !cpu_aux_abort && !pend_write;

   logic [31:0] scratch_q [4];
   logic [31:0] scratch_d [4];
   logic [31:0] timer_q, timer_d;
   logic [31:0] cmp_q, cmp_d;
   logic        status_q, status_d;
   logic        ctrl_q, ctrl_d;
   logic        match_clr;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) scratch_d[i] = scratch_q[i];
      timer_d   = timer_q + 32'd1;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      match_clr = 1'b0;
      if (wr_commit) begin
         case (pend_idx)
            6'd0, 6'd1, 6'd2, 6'd3:
               scratch_d[pend_idx[1:0]] = merge_bytes(scratch_q[pend_idx[1:0]], pend_wdata, pend_wstrb);
            // unstrobed timer bytes keep counting, so wstrb=0 leaves the timer untouched
            IDX_TIMER:  timer_d   = merge_bytes(timer_d, pend_wdata, pend_wstrb);
            IDX_CMP:    cmp_d     = merge_bytes(cmp_q, pend_wdata, pend_wstrb);
            IDX_STATUS: match_clr = pend_wstrb[0] && pend_wdata[0];
            IDX_CTRL:   if (pend_wstrb[0]) ctrl_d = pend_wdata[0];
            default: ;
         endcase
      end
      // a match on the same edge as a clear keeps the bit set
      status_d = (timer_d == cmp_q) || (status_q && !match_clr);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 4; i++) scratch_q[i] <= '0;
         timer_q  <= '0;
         cmp_q    <= '1;
         status_q <= 1'b0;
         ctrl_q   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) scratch_q[i] <= scratch_d[i];
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         status_q <= status_d;
         ctrl_q   <= ctrl_d;
      end
   end

   // Read mux sees pre-edge values, so a same-cycle write is not visible
   logic [31:0] rd_word;

   always_comb begin
      rd_word = '0;
      case (pend_idx)
         6'd0, 6'd1, 6'd2, 6'd3: rd_word = scratch_q[pend_idx[1:0]];
         IDX_TIMER:  rd_word = timer_q;
         IDX_CMP:    rd_word = cmp_q;
         IDX_STATUS: rd_word = {31'd0, status_q};
         IDX_CTRL:   rd_word = {31'd0, ctrl_q};
         default:    rd_word = '0;
      endcase
   end

   // Return pipeline holds zeros in empty slots so outputs are OR-combinable
   logic        ret_valid [READ_LATENCY];
   logic [31:0] ret_data  [READ_LATENCY];
   logic [8:0]  ret_tag   [READ_LATENCY];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            ret_valid[i] <= 1'b0;
            ret_data[i]  <= '0;
            ret_tag[i]   <= '0;
         end
      end else begin
         ret_valid[0] <= rd_commit;
         ret_data[0]  <= rd_commit ? rd_word : '0;
         ret_tag[0]   <= rd_commit ? pend_wdata[8:0] : '0;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            ret_valid[i] <= ret_valid[i-1];
            ret_data[i]  <= ret_data[i-1];
            ret_tag[i]   <= ret_tag[i-1];
         end
      end
   end

   assign cpu_aux_rvalid = ret_valid[READ_LATENCY-1];
   assign cpu_aux_rdata  = ret_data[READ_LATENCY-1];
   assign cpu_aux_rtag   = ret_tag[READ_LATENCY-1];
   assign irq            = status_q && ctrl_q;

endmodule

// File: tb/tb_aux_responder.sv
// Self-checking bench for aux_responder: per-cycle reference model, a write/read
// vector table, and directed sequences for abort, ordering, match/clear and reset.
module tb_aux_responder;

   localparam int          L    = 2;
   localparam logic [31:0] BASE = 32'hE000_0000;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        req_i;
   logic [31:0] addr_i;
   logic        write_i;
   logic [3:0]  wstrb_i;
   logic [31:0] wdata_i;
   logic        abort_i;
   logic        rvalid;
   logic [31:0] rdata;
   logic [8:0]  rtag;
   logic        irq;

   aux_responder #(.BASE_ADDR(BASE), .READ_LATENCY(L)) dut (
      .clock(clock), .reset(rst_n),
      .cpu_aux_request(req_i), .cpu_aux_addr(addr_i), .cpu_aux_write(write_i),
      .cpu_aux_wstrb(wstrb_i), .cpu_aux_wdata(wdata_i), .cpu_aux_abort(abort_i),
      .cpu_aux_rvalid(rvalid), .cpu_aux_rdata(rdata), .cpu_aux_rtag(rtag), .irq(irq)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int due; logic [31:0] data; logic [8:0] tag; } ret_t;
   typedef struct { int at; logic [31:0] data; logic [8:0] tag; } obs_t;

   ret_t        rq[$];
   obs_t        log_q[$];
   logic [31:0] m_scr [4];
   logic [31:0] m_timer, m_cmp;
   logic        m_status, m_ctrl;
   logic        p_valid, p_write;
   int          p_idx;
   logic [3:0]  p_strb;
   logic [31:0] p_data;
   logic        obs_rvalid, obs_irq;
   logic [31:0] obs_rdata;
   logic [8:0]  obs_rtag;

   function automatic logic [31:0] apply_strobes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                 input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   function automatic logic [31:0] mread(input int idx);
      if (idx < 4)   return m_scr[idx];
      if (idx == 4)  return m_timer;
      if (idx == 5)  return m_cmp;
      if (idx == 6)  return {31'd0, m_status};
      if (idx == 7)  return {31'd0, m_ctrl};
      return 32'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_scr[i] = '0;
      m_timer = '0; m_cmp = '1; m_status = 0; m_ctrl = 0;
      p_valid = 0; p_write = 0; p_idx = 0; p_strb = '0; p_data = '0;
      rq.delete();
   endtask

   task automatic model_step(input logic req, input logic [31:0] addr, input logic wr,
                             input logic [3:0] s, input logic [31:0] wd, input logic ab);
      logic [31:0] t_next, old_cmp;
      logic        clr;
      ret_t        e;
      t_next = m_timer + 32'd1;
      old_cmp = m_cmp;
      clr = 0;
      if (p_valid && !ab) begin
         if (!p_write) begin
            e.due = cyc + L; e.data = mread(p_idx); e.tag = p_data[8:0];
            rq.push_back(e);
         end else if (p_idx < 4) m_scr[p_idx] = apply_strobes(m_scr[p_idx], p_data, p_strb);
         else if (p_idx == 4) t_next = apply_strobes(t_next, p_data, p_strb);
         else if (p_idx == 5) m_cmp = apply_strobes(m_cmp, p_data, p_strb);
         else if (p_idx == 6) clr = p_strb[0] & p_data[0];
         else if (p_idx == 7 && p_strb[0]) m_ctrl = p_data[0];
      end
      m_status = (t_next == old_cmp) | (m_status & ~clr);
      m_timer  = t_next;
      p_valid  = req && (addr[31:8] == BASE[31:8]);
      p_write  = wr;
      p_idx    = int'(addr[7:2]);
      p_strb   = s;
      p_data   = wd;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input logic req, input logic [31:0] addr, input logic wr,
                        input logic [3:0] s, input logic [31:0] wd, input logic ab);
      ret_t e;
      logic exp_v;
      obs_t o;
      req_i = req; addr_i = addr; write_i = wr; wstrb_i = s; wdata_i = wd; abort_i = ab;
      @(negedge clock);
      exp_v = 0; e.due = 0; e.data = '0; e.tag = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         e = rq.pop_front();
         exp_v = 1;
      end
      obs_rvalid = rvalid; obs_rdata = rdata; obs_rtag = rtag; obs_irq = irq;
      check("cycle_out", {21'd0, rvalid, rdata, rtag, irq}, {21'd0, exp_v, e.data, e.tag, m_status & m_ctrl});
      if (rvalid) begin
         o.at = cyc; o.data = rdata; o.tag = rtag;
         log_q.push_back(o);
      end
      model_step(req, addr, wr, s, wd, ab);
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic idle();
      cycle(0, '0, 0, '0, '0, 0);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [8:0] tag);
      cycle(1, addr, 0, '0, {23'd0, tag}, 0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] s);
      cycle(1, addr, 1, s, data, 0);
   endtask

   task automatic wait_rvalid(input int max_cycles, output logic found, output int lat,
                              output logic [31:0] data, output logic [8:0] tag);
      found = 0; lat = 0; data = '0; tag = '0;
      for (int k = 1; k <= max_cycles && !found; k++) begin
         idle();
         if (obs_rvalid) begin
            found = 1; lat = k; data = obs_rdata; tag = obs_rtag;
         end
      end
   endtask

   task automatic do_reset();
      req_i = 0; addr_i = '0; write_i = 0; wstrb_i = '0; wdata_i = '0; abort_i = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_outputs", {21'd0, rvalid, rdata, rtag, irq}, 64'd0);
      @(posedge clock);
      #1;
      rst_n = 1;
      cyc = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; logic [31:0] exp; } vec_t;
   vec_t vt[11];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        found;
      int          lat, start, k, tcyc;
      logic [31:0] d, ra, rw, rs;
      logic [8:0]  t;
      logic [31:0] offs [5];

      vt[0]  = '{BASE + 32'h04, 4'b0101, 32'hDEADBEEF, 32'h00AD00EF};
      vt[1]  = '{BASE + 32'h08, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vt[2]  = '{BASE + 32'h08, 4'b1000, 32'h12345678, 32'h12FFFFFF};
      vt[3]  = '{BASE + 32'h0C, 4'b0000, 32'hA5A5A5A5, 32'h00000000};
      vt[4]  = '{BASE + 32'h1C, 4'b1111, 32'hFFFFFFFF, 32'h00000001};
      vt[5]  = '{BASE + 32'h1C, 4'b1110, 32'h00000000, 32'h00000001};
      vt[6]  = '{BASE + 32'h1C, 4'b0001, 32'h00000000, 32'h00000000};
      vt[7]  = '{BASE + 32'h14, 4'b0011, 32'h0000ABCD, 32'hFFFFABCD};
      vt[8]  = '{BASE + 32'h20, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
      vt[9]  = '{BASE + 32'h03, 4'b1111, 32'h11223344, 32'h11223344};
      vt[10] = '{BASE + 32'h18, 4'b1111, 32'hFFFFFFFF, 32'h00000000};

      do_reset();

      // Reset then idle
      repeat (3) idle();
      check("idle_outputs", {21'd0, obs_rvalid, obs_rdata, obs_rtag, obs_irq}, 64'd0);

      // Timer read at cycle 10
      while (cyc < 10) idle();
      rd(BASE + 32'h10, 9'h1A5);
      wait_rvalid(10, found, lat, d, t);
      check("timer_rd_found", 64'(found), 64'd1);
      check("timer_rd_latency", 64'(lat), 64'(L + 1));
      check("timer_rd_tag", 64'(t), 64'h1A5);
      check("timer_rd_data", 64'(d), 64'd11);

      // Aborted write, then aborted read
      wr(BASE + 32'h00, 32'h12345678, 4'hF);
      cycle(0, '0, 0, '0, '0, 1);
      rd(BASE + 32'h00, 9'h007);
      wait_rvalid(10, found, lat, d, t);
      check("abort_wr_found", 64'(found), 64'd1);
      check("abort_wr_data", 64'(d), 64'd0);
      log_q.delete();
      rd(BASE + 32'h00, 9'h003);
      cycle(0, '0, 0, '0, '0, 1);
      repeat (8) idle();
      check("abort_rd_no_rvalid", 64'(log_q.size()), 64'd0);

      // Back-to-back reads, in-order return
      offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08; offs[3] = 32'h0C; offs[4] = 32'h40;
      log_q.delete();
      start = cyc;
      for (int i = 0; i < 5; i++) rd(BASE + offs[i], 9'(i + 1));
      repeat (8) idle();
      check("b2b_count", 64'(log_q.size()), 64'd5);
      for (int i = 0; i < 5 && i < log_q.size(); i++) begin
         check("b2b_tag", 64'(log_q[i].tag), 64'(i + 1));
         check("b2b_cycle", 64'(log_q[i].at), 64'(start + L + 1 + i));
         check("b2b_data", 64'(log_q[i].data), 64'd0);
      end
      log_q.delete();
      rd(32'hD000_0000, 9'h055);
      repeat (8) idle();
      check("out_of_window_no_rvalid", 64'(log_q.size()), 64'd0);

      // Table: write then read next cycle
      do_reset();
      for (int i = 0; i < 11; i++) begin
         wr(vt[i].addr, vt[i].wdata, vt[i].strb);
         rd(vt[i].addr, 9'(i + 16));
         wait_rvalid(10, found, lat, d, t);
         check("vec_found", 64'(found), 64'd1);
         check("vec_tag", 64'(t), 64'(i + 16));
         check("vec_data", 64'(d), 64'(vt[i].exp));
      end

      // Timer compare, irq, clear, and clear on the match edge
      wr(BASE + 32'h1C, 32'h1, 4'hF);
      wr(BASE + 32'h14, 32'h20, 4'hF);
      wr(BASE + 32'h10, 32'h10, 4'hF);
      k = 0; found = 0;
      for (int i = 1; i <= 40 && !found; i++) begin
         idle();
         if (obs_irq) begin found = 1; k = i; end
      end
      check("irq_rise_found", 64'(found), 64'd1);
      check("irq_rise_cycle", 64'(k), 64'd18);
      repeat (5) idle();
      check("irq_sticky", 64'(obs_irq), 64'd1);
      wr(BASE + 32'h18, 32'h1, 4'h1);
      idle(); idle();
      check("irq_cleared", 64'(obs_irq), 64'd0);
      wr(BASE + 32'h10, 32'h10, 4'hF);
      repeat (15) idle();
      check("pre_match_irq", 64'(obs_irq), 64'd0);
      wr(BASE + 32'h18, 32'h1, 4'hF);
      idle(); idle();
      check("clear_on_match_set_wins", 64'(obs_irq), 64'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rs = $urandom_range(0, 9);
         rw = $urandom;
         if (rs < 8)       ra = BASE + (rs << 2) + {30'd0, rw[1:0]};
         else if (rs == 8) ra = BASE + 32'h40 + {24'd0, rw[7:0]};
         else              ra = 32'hD000_0000 | {24'd0, rw[7:0]};
         d = $urandom;
         cycle($urandom_range(0, 3) != 0, ra, rw[8],
               (rs == 4) ? 4'hF : rw[15:12], d, $urandom_range(0, 4) == 0);
      end
      repeat (6) idle();

      // Reset while a read is in its return latency
      wr(BASE + 32'h04, 32'hCAFEF00D, 4'hF);
      wr(BASE + 32'h14, 32'h1234, 4'hF);
      wr(BASE + 32'h1C, 32'h1, 4'hF);
      rd(BASE + 32'h04, 9'h0AA);
      idle();
      do_reset();
      log_q.delete();
      repeat (10) idle();
      check("reset_no_rvalid", 64'(log_q.size()), 64'd0);
      rd(BASE + 32'h04, 9'h0B0);
      wait_rvalid(10, found, lat, d, t);
      check("rst_scratch1", {31'd0, found, d}, {31'd0, 1'b1, 32'd0});
      rd(BASE + 32'h14, 9'h0B1);
      wait_rvalid(10, found, lat, d, t);
      check("rst_cmp", {31'd0, found, d}, {31'd0, 1'b1, 32'hFFFFFFFF});
      rd(BASE + 32'h1C, 9'h0B2);
      wait_rvalid(10, found, lat, d, t);
      check("rst_ctrl", {31'd0, found, d}, {31'd0, 1'b1, 32'd0});
      rd(BASE + 32'h18, 9'h0B3);
      wait_rvalid(10, found, lat, d, t);
      check("rst_status", {31'd0, found, d}, {31'd0, 1'b1, 32'd0});
      tcyc = cyc;
      rd(BASE + 32'h10, 9'h0B4);
      wait_rvalid(10, found, lat, d, t);
      check("rst_timer", {31'd0, found, d}, {31'd0, 1'b1, 32'(tcyc + 1)});
      check("rst_irq", 64'(obs_irq), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aux_responder.md
# aux_responder

Target-side endpoint of the CPU auxiliary bus. It decodes requests from the CPU memory interface (request/addr/write/wstrb/wdata, with a one-cycle-late abort) and serves a small register window: four scratch registers, a free-running timer with compare, and a sticky status/interrupt. It returns read data with the request tag on the aux read-return path, and its outputs are zero when idle so several responders can be OR-combined into the CPU readpath.

## Interface
- BASE_ADDR, 32'hE000_0000: window base; a request hits when addr[31:8] == BASE_ADDR[31:8].
- READ_LATENCY, 2: cycles from commit (request+1) to rvalid; legal range 1..8.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_aux_request  in  1  request valid, one cycle per transaction
- cpu_aux_addr  in  32  byte address; addr[1:0] ignored
- cpu_aux_write  in  1  1=write, 0=read
- cpu_aux_wstrb  in  4  byte enables for writes
- cpu_aux_wdata  in  32  write data; for reads, wdata[8:0] is the tag
- cpu_aux_abort  in  1  cancels the request issued in the previous cycle
- cpu_aux_rvalid  out  1  read data valid, one-cycle pulse
- cpu_aux_rdata  out  32  read data; 0 when rvalid=0
- cpu_aux_rtag  out  9  returned tag; 0 when rvalid=0
- irq  out  1  interrupt: STATUS[0] & CTRL[0]

## Operation
- Register map (offset = addr[7:0]):
  - 0x00-0x0C SCRATCH0-3: RW, reset 0.
  - 0x10 TIMER: RW; increments by 1 every cycle (wraps 0xFFFFFFFF→0); a committed write loads the strobed bytes, and the write wins over the increment that cycle.
  - 0x14 TIMER_CMP: RW, reset 0xFFFFFFFF.
  - 0x18 STATUS: bit0 MATCH, sticky, set when the next TIMER value equals TIMER_CMP; write-1-to-clear on bit0. Set and clear in the same cycle: set wins. Other bits read 0.
  - 0x1C CTRL: bit0 IRQ_EN, RW; other bits read 0 and ignore writes.
  - Other offsets in the window: read 0, writes ignored. Out-of-window requests: ignored entirely, no rvalid.
- Byte strobes apply per byte on every writable register. wstrb=0 is a legal no-op write.
- Pipeline:
  - S0 (cycle T): on request with a window hit, capture write, offset, wstrb, wdata/tag into a pending slot.
  - S1 (cycle T+1): if cpu_aux_abort=1, discard pending with no side effect. Otherwise commit. A write updates the register at the T+1 clock edge. A read samples the register value as of T+1, before any write committing in the same cycle, and enters a READ_LATENCY-deep return shift register.
- Back-to-back requests every cycle are legal; there is no ready/backpressure. A new request at T+1 is captured while the T request commits. Abort at T+1 applies only to the T request.
- Read-after-write to the same register in consecutive cycles: the read at T+1 commits at T+2, so it returns the value written at T.
- Reset (async, low): SCRATCH/TIMER/STATUS/CTRL = 0, TIMER_CMP = 0xFFFFFFFF, pending slot and return pipeline cleared, all outputs 0. Reads in flight are lost; reset mid-transaction produces no rvalid after deassertion.

## Timing
- Read request at T, no abort: cpu_aux_rvalid=1 at cycle T+1+READ_LATENCY (default T+3) for exactly one cycle, with rtag = wdata[8:0] captured at T.
- Write at T: effect is visible at T+2 (register value after the T+1 edge).
- One rvalid per committed read; ordering is preserved; throughput is one transaction per cycle.
- MATCH sets on the edge where TIMER becomes equal to TIMER_CMP. irq follows combinationally from the STATUS/CTRL flops, with no extra delay.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: all outputs 0. Read TIMER at cycle 10 with tag 0x1A5 → rvalid at request+3, rtag=0x1A5, rdata equals the cycle count since reset at commit.
- Write SCRATCH1=0xDEADBEEF with wstrb=4'b0101, then read it next cycle → rdata=0x00AD00EF.
- Write SCRATCH0=0x12345678 with cpu_aux_abort=1 the next cycle, then read SCRATCH0 → 0x00000000. Read tag 0x003 with abort → no rvalid ever.
- Reads every cycle to offsets 0x00, 0x04, 0x08, 0x0C, 0x40 with tags 1-5 → five consecutive rvalids in order, tag 5 data 0. A read to 0xD0000000 → no rvalid.
- Set TIMER_CMP=0x20 and CTRL=1, write TIMER=0x10 → irq rises when TIMER reaches 0x20 and stays high. Write STATUS=1 → irq low. Clear on the exact match cycle → bit stays set.
- Assert reset during a read's return latency → no rvalid after release, and all registers at their reset values.
